// File: rtl/usb_uart_buffer.sv
// TX/RX byte FIFOs between the CPU port and usb_uart_core; at most 1 byte per 3 cycles each way.
// Latency: TX head to uart_wr 1 cycle; uart_valid to rx_level 1 cycle. uart_busy stalls TX; a full RX withholds uart_rd.
// Optional USB_UART_FLUSH_ON_DISCONNECT_EN: discard TX data while host_presence is low.

module usb_uart_fifo #(
   parameter int AW = 4,
   parameter int W  = 8
) (
   input  logic          clk_48mhz,
   input  logic          reset,
   input  logic          push,
   input  logic [W-1:0]  push_dat,
   input  logic          pop,
   input  logic          flush,
   output logic [W-1:0]  head_dat,
   output logic [AW:0]   level,
   output logic          full,
   output logic          empty
);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic [W-1:0] mem_q [2**AW];
   logic         do_push;
   logic         do_pop;

   assign level    = wr_ptr - rd_ptr;
   assign full     = level[AW];
   assign empty    = (level == '0);
   assign do_pop   = pop && !empty;
   // A pop in the same cycle frees the slot, so a push at full still lands.
   assign do_push  = push && (!full || do_pop);
   assign head_dat = mem_q[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_48mhz) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (flush)
            rd_ptr <= wr_ptr;
         else if (do_pop)
            rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk_48mhz) begin
      if (do_push)
         mem_q[wr_ptr[AW-1:0]] <= push_dat;
   end
endmodule

module usb_uart_buffer #(
   parameter int TX_AW = 4,
   parameter int RX_AW = 4
) (
   input  logic             clk_48mhz,
   input  logic             reset,
   input  logic             host_presence,
   input  logic             cpu_tx_wr,
   input  logic [7:0]       cpu_tx_data,
   output logic             cpu_tx_full,
   input  logic             cpu_rx_rd,
   output logic [7:0]       cpu_rx_data,
   output logic             cpu_rx_empty,
   output logic [TX_AW:0]   tx_level,
   output logic [RX_AW:0]   rx_level,
   output logic             tx_overflow,
   output logic             uart_wr,
   output logic [7:0]       uart_tx_data,
   input  logic             uart_busy,
   output logic             uart_rd,
   input  logic [7:0]       uart_rx_data,
   input  logic             uart_valid
);
   typedef enum logic [1:0] {T_IDLE, T_SEND, T_GAP} tx_state_t;
   typedef enum logic [1:0] {R_IDLE, R_ACK, R_GAP} rx_state_t;

   tx_state_t  tx_state, tx_state_nxt;
   rx_state_t  rx_state, rx_state_nxt;

   logic       tx_push, tx_pop, tx_flush, tx_full, tx_empty;
   logic [7:0] tx_head;
   logic       uart_wr_nxt;
   logic [7:0] uart_tx_data_nxt;

   logic       rx_push, rx_full, rx_empty;
   logic       uart_rd_nxt;

`ifdef USB_UART_FLUSH_ON_DISCONNECT_EN
   // With no host, writes vanish silently so firmware never blocks on a dead link.
   assign tx_flush    = !host_presence;
   assign tx_push     = cpu_tx_wr && host_presence;
   assign cpu_tx_full = tx_full && host_presence;
`else
   assign tx_flush    = 1'b0;
   assign tx_push     = cpu_tx_wr;
   assign cpu_tx_full = tx_full;
`endif

   usb_uart_fifo #(.AW(TX_AW), .W(8)) u_tx_fifo (
      .clk_48mhz (clk_48mhz),
      .reset     (reset),
      .push      (tx_push),
      .push_dat  (cpu_tx_data),
      .pop       (tx_pop),
      .flush     (tx_flush),
      .head_dat  (tx_head),
      .level     (tx_level),
      .full      (tx_full),
      .empty     (tx_empty)
   );

   usb_uart_fifo #(.AW(RX_AW), .W(8)) u_rx_fifo (
      .clk_48mhz (clk_48mhz),
      .reset     (reset),
      .push      (rx_push),
      .push_dat  (uart_rx_data),
      .pop       (cpu_rx_rd),
      .flush     (1'b0),
      .head_dat  (cpu_rx_data),
      .level     (rx_level),
      .full      (rx_full),
      .empty     (rx_empty)
   );

   assign cpu_rx_empty = rx_empty;

   always_ff @(posedge clk_48mhz) begin
      if (reset)
         tx_overflow <= 1'b0;
      else if (tx_push && tx_full && !tx_pop)
         tx_overflow <= 1'b1;
   end

   always_ff @(posedge clk_48mhz) begin
      if (reset) begin
         tx_state     <= T_IDLE;
         uart_wr      <= 1'b0;
         uart_tx_data <= 8'h00;
      end else begin
         tx_state     <= tx_state_nxt;
         uart_wr      <= uart_wr_nxt;
         uart_tx_data <= uart_tx_data_nxt;
      end
   end

   always_comb begin
      tx_state_nxt     = tx_state;
      tx_pop           = 1'b0;
      uart_wr_nxt      = 1'b0;
      uart_tx_data_nxt = uart_tx_data;
      unique case (tx_state)
         T_IDLE: begin
            if (!tx_empty && !uart_busy && host_presence) begin
               tx_state_nxt     = T_SEND;
               tx_pop           = 1'b1;
               uart_wr_nxt      = 1'b1;
               uart_tx_data_nxt = tx_head;
            end
         end
         T_SEND:  tx_state_nxt = T_GAP;
         // Gives the core a cycle to raise uart_busy before we look again.
         T_GAP:   tx_state_nxt = T_IDLE;
         default: tx_state_nxt = T_IDLE;
      endcase
   end

   always_ff @(posedge clk_48mhz) begin
      if (reset) begin
         rx_state <= R_IDLE;
         uart_rd  <= 1'b0;
      end else begin
         rx_state <= rx_state_nxt;
         uart_rd  <= uart_rd_nxt;
      end
   end

   always_comb begin
      rx_state_nxt = rx_state;
      rx_push      = 1'b0;
      uart_rd_nxt  = 1'b0;
      unique case (rx_state)
         R_IDLE: begin
            if (uart_valid && !rx_full) begin
               rx_state_nxt = R_ACK;
               rx_push      = 1'b1;
               uart_rd_nxt  = 1'b1;
            end
         end
         R_ACK:   rx_state_nxt = R_GAP;
         // uart_valid is stale here while the core retires the acked byte.
         R_GAP:   rx_state_nxt = R_IDLE;
         default: rx_state_nxt = R_IDLE;
      endcase
   end
endmodule

// File: tb/tb_usb_uart_buffer.sv
// Randomized bench: queue-based model of both byte paths plus an emulated core RX source.
module tb_usb_uart_buffer;
   logic       clk_48mhz = 1'b0;
   logic       reset, host_presence, cpu_tx_wr, cpu_rx_rd, uart_busy, uart_valid;
   logic [7:0] cpu_tx_data, uart_rx_data, cpu_rx_data, uart_tx_data;
   logic       cpu_tx_full, cpu_rx_empty, tx_overflow, uart_wr, uart_rd;
   logic [4:0] tx_level, rx_level;

   always #5 clk_48mhz = ~clk_48mhz;

   usb_uart_buffer #(.TX_AW(4), .RX_AW(4)) dut (
      .clk_48mhz     (clk_48mhz),
      .reset         (reset),
      .host_presence (host_presence),
      .cpu_tx_wr     (cpu_tx_wr),
      .cpu_tx_data   (cpu_tx_data),
      .cpu_tx_full   (cpu_tx_full),
      .cpu_rx_rd     (cpu_rx_rd),
      .cpu_rx_data   (cpu_rx_data),
      .cpu_rx_empty  (cpu_rx_empty),
      .tx_level      (tx_level),
      .rx_level      (rx_level),
      .tx_overflow   (tx_overflow),
      .uart_wr       (uart_wr),
      .uart_tx_data  (uart_tx_data),
      .uart_busy     (uart_busy),
      .uart_rd       (uart_rd),
      .uart_rx_data  (uart_rx_data),
      .uart_valid    (uart_valid)
   );

   int n_vec = 0;
   int n_bad = 0;

   // reference model state
   byte unsigned txq[$];
   byte unsigned rxq[$];
   byte unsigned src[$];
   bit           m_ovf, exp_wr, exp_rd;
   byte unsigned exp_txd;
   int           tx_gap, rx_gap, ci, mi;

   // stimulus knobs (percentages) and controls
   int p_wr, p_busy, p_rd, p_src;
   bit pres, rst_req;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      txq.delete();
      rxq.delete();
      m_ovf   = 0;
      exp_wr  = 0;
      exp_rd  = 0;
      exp_txd = 0;
      tx_gap  = 0;
      rx_gap  = 0;
      mi      = ci;
   endtask

   // One clock of the spec's rules applied to the inputs about to be sampled.
   task automatic model_step();
      int  tsz, rsz;
      bit  send, wr_ok, rpop, acc;
      if (reset) begin
         model_reset();
         return;
      end
      tsz  = txq.size();
      send = (tx_gap == 0) && (tsz > 0) && !uart_busy && host_presence;
      if (tx_gap > 0) tx_gap--;
      exp_wr = send;
      if (send) begin
         exp_txd = txq.pop_front();
         tx_gap  = 2;
      end
`ifdef USB_UART_FLUSH_ON_DISCONNECT_EN
      wr_ok = cpu_tx_wr && host_presence;
`else
      wr_ok = cpu_tx_wr;
`endif
      if (wr_ok) begin
         if (tsz < 16 || send) txq.push_back(cpu_tx_data);
         else m_ovf = 1;
      end
`ifdef USB_UART_FLUSH_ON_DISCONNECT_EN
      if (!host_presence) txq.delete();
`endif
      rsz  = rxq.size();
      rpop = cpu_rx_rd && (rsz > 0);
      acc  = (rx_gap == 0) && (mi < src.size()) && (rsz < 16);
      if (rx_gap > 0) rx_gap--;
      exp_rd = acc;
      if (rpop) void'(rxq.pop_front());
      if (acc) begin
         rxq.push_back(src[mi]);
         mi++;
         rx_gap = 2;
      end
   endtask

   task automatic cycle();
      logic full_exp;
      @(negedge clk_48mhz);
`ifdef USB_UART_FLUSH_ON_DISCONNECT_EN
      full_exp = (txq.size() == 16) && host_presence;
`else
      full_exp = (txq.size() == 16);
`endif
      chk("uart_wr",      uart_wr,      exp_wr);
      chk("uart_tx_data", uart_tx_data, exp_txd);
      chk("tx_level",     tx_level,     txq.size());
      chk("cpu_tx_full",  cpu_tx_full,  full_exp);
      chk("tx_overflow",  tx_overflow,  m_ovf);
      chk("uart_rd",      uart_rd,      exp_rd);
      chk("rx_level",     rx_level,     rxq.size());
      chk("cpu_rx_empty", cpu_rx_empty, rxq.size() == 0);
      if (rxq.size() > 0) chk("cpu_rx_data", cpu_rx_data, rxq[0]);

      reset         = rst_req;
      host_presence = pres;
      uart_busy     = ($urandom_range(99) < p_busy);
      cpu_tx_wr     = ($urandom_range(99) < p_wr);
      cpu_tx_data   = 8'($urandom);
      cpu_rx_rd     = ($urandom_range(99) < p_rd);
      if ($urandom_range(99) < p_src) src.push_back(8'($urandom));
      // Emulated core: byte held on uart_valid until it samples uart_rd.
      uart_valid   = (ci < src.size());
      uart_rx_data = uart_valid ? src[ci] : 8'h00;
      if (uart_rd && uart_valid) ci++;
      model_step();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      reset = 1; host_presence = 1; cpu_tx_wr = 0; cpu_tx_data = 0; cpu_rx_rd = 0;
      uart_busy = 0; uart_valid = 0; uart_rx_data = 0;
      ci = 0; model_reset();
      pres = 1; rst_req = 1; p_wr = 0; p_busy = 0; p_rd = 0; p_src = 0;
      run(2);
      rst_req = 0;
      // light TX traffic, core always ready
      p_wr = 20; run(60);
      // core busy: fill TX and overflow, then drain
      p_busy = 100; p_wr = 60; run(60);
      p_busy = 0; p_wr = 0; run(80);
      // RX: fill to 16 with data pending, then drain at two rates
      p_src = 50; run(120);
      p_rd = 10; run(100);
      p_rd = 60; run(100);
      p_src = 0; p_rd = 50; run(60);
      // TX near-full with concurrent push/pop, pointer wrap
      p_wr = 90; run(200);
      p_wr = 0; run(60);
      // host absent with bytes queued, then host returns
      p_wr = 50; run(10);
      pres = 0; run(40);
      pres = 1; p_wr = 0; run(60);
      // reset mid-operation
      p_wr = 60; p_src = 40; p_busy = 30; p_rd = 30; run(30);
      rst_req = 1; run(1);
      rst_req = 0; run(100);
      // mixed traffic with presence toggling
      for (int k = 0; k < 40; k++) begin
         pres   = ($urandom_range(99) < 75);
         p_wr   = $urandom_range(80);
         p_busy = $urandom_range(60);
         p_rd   = $urandom_range(80);
         p_src  = $urandom_range(80);
         run(50);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
